arinc_tx_scheduler: RTL and testbench
=====================================

ARINC_TX_SCHEDULER -- requirements
Module: arinc_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of word requesters sharing one ARINC 429 encoder (2..8).
REQ-002 Parameter GAP_CYCLES, default 16: minimum idle clk cycles between the encoder busy fall and the next load.
REQ-003 Parameter TIMEOUT, default 1023: max clk cycles in LOAD waiting for the encoder busy rise.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 clr  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  NREQ  per-requester word-pending level.
REQ-007 word  in  32*NREQ  per-requester 32-bit ARINC word; requester i occupies bits [32i+31:32i].
REQ-008 ack  out  NREQ  one-cycle pulse per requester: word captured, source may drop req.
REQ-009 speed_req  in  1  requested line rate (1 = high speed, 0 = low speed).
REQ-010 enc_data  out  32  word presented to the encoder.
REQ-011 enc_load  out  1  encoder load strobe.
REQ-012 enc_speed  out  1  encoder speed select.
REQ-013 enc_busy  in  1  encoder busy; asynchronous to the FSM, passed through a 2-flop synchronizer before use.
REQ-014 grant_id  out  3  index of the last granted requester.
REQ-015 sched_busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 timeout_err  out  1  sticky load-timeout flag.
REQ-017 err_clr  in  1  clears timeout_err.

Function
REQ-018 FSM states IDLE, LOAD, SEND, GAP, stored in a registered state variable.
REQ-019 IDLE: when any req bit is high, round-robin select starting at grant_id+1 (mod NREQ); on that edge capture the word into enc_data, pulse ack for exactly one cycle, update grant_id, go to LOAD.
REQ-020 Latency: req high at edge N in IDLE -> ack high during cycle N+1, enc_load high from cycle N+1.
REQ-021 A req that is dropped before it is granted is not served and is not acked.
REQ-022 LOAD: hold enc_load=1 and enc_data stable; on the synchronized busy rising edge clear enc_load and go to SEND.
REQ-023 LOAD timeout: when the LOAD cycle counter reaches TIMEOUT, set timeout_err, clear enc_load, and go to GAP; the word is dropped and not retried.
REQ-024 SEND: wait for the synchronized busy falling edge, then go to GAP; there is no timeout in SEND.
REQ-025 GAP: count GAP_CYCLES cycles, then go to IDLE; req is ignored during GAP.
REQ-026 enc_speed loads speed_req only in IDLE while the synchronized busy is low; it is never changed mid-word.
REQ-027 enc_data is held from capture until the next capture.
REQ-028 err_clr and a timeout in the same cycle: the set wins.
REQ-029 The counter is 16 bits wide, is reset on every state entry, and saturates (never wraps).

Reset
REQ-030 On clr low: state=IDLE, enc_data=0, enc_load=0, enc_speed=1, ack=0, grant_id=NREQ-1 (requester 0 wins first), sched_busy=0, timeout_err=0, synchronizer=0, counter=0.
REQ-031 clr asserted mid-word aborts immediately; no ack is reissued after release.

Configuration
REQ-032 Macro ARINC_TX_PARITY_EN defined: at capture, enc_data[31] is replaced with the odd parity of word bits [30:0].
REQ-033 ARINC_TX_PARITY_EN undefined: enc_data equals the requester word bit-for-bit.

Verification
REQ-034 req=4'b0001, word0=32'h0000_00A5, encoder model busy for 100 cycles -> ack=0001 once, enc_data=0000_00A5, enc_load falls after the busy rise, next load no sooner than 16 cycles after the busy fall.
REQ-035 req=4'b1111 held continuously -> grant order 0,1,2,3,0, with exactly one ack per word.
REQ-036 Encoder model never raises busy -> timeout_err=1 after 1023 LOAD cycles, FSM returns to IDLE via GAP; err_clr pulse -> timeout_err=0.
REQ-037 speed_req toggles 1->0 during SEND -> enc_speed stays 1 until IDLE with busy low, then becomes 0.
REQ-038 With ARINC_TX_PARITY_EN, word=32'h0000_0001 -> enc_data=32'h0000_0001; word=32'h0000_0003 -> enc_data=32'h8000_0003.
REQ-039 clr pulsed low during SEND -> all outputs at reset values; with req=4'b0010 after release, requester 1 is granted.

Source files
------------

// File: rtl/arinc_tx_scheduler_if.sv
// Requester and encoder signal bundle for arinc_tx_scheduler.
// The master side is the environment (requesters and encoder); the slave side is the scheduler.
interface arinc_tx_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   word;
    logic [NREQ-1:0]      ack;
    logic                 speed_req;
    logic [31:0]          enc_data;
    logic                 enc_load;
    logic                 enc_speed;
    logic                 enc_busy;
    logic [2:0]           grant_id;
    logic                 sched_busy;
    logic                 timeout_err;
    logic                 err_clr;

    modport master (
        output req, word, speed_req, enc_busy, err_clr,
        input  ack, enc_data, enc_load, enc_speed, grant_id, sched_busy, timeout_err
    );

    modport slave (
        input  req, word, speed_req, enc_busy, err_clr,
        output ack, enc_data, enc_load, enc_speed, grant_id, sched_busy, timeout_err
    );
endinterface

// File: rtl/arinc_tx_scheduler.sv
// Round-robin scheduler feeding one ARINC 429 encoder from NREQ word requesters.
// Optional macro ARINC_TX_PARITY_EN: replace bit 31 of each captured word with odd parity of bits [30:0].
module arinc_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1023
) (
    input logic                 clk,
    input logic                 clr,
    arinc_tx_scheduler_if.slave bus
);
    localparam int          IW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
    localparam logic [15:0] GAP_LAST    = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t          state;
    logic [15:0]     cnt;
    logic            busy_s1, busy_s2, busy_d;
    logic [NREQ-1:0] ack;
    logic [31:0]     enc_data;
    logic            enc_load, enc_speed, sched_busy, timeout_err;
    logic [2:0]      grant_id;

    logic            sel_valid;
    logic [2:0]      sel_idx;
    logic [IW:0]     cand;
    logic [31:0]     sel_word;
    logic            busy_rise, busy_fall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] format_word(input logic [31:0] w);
`ifdef ARINC_TX_PARITY_EN
        return {~^w[30:0], w[30:0]};
`else
        return w;
`endif
    endfunction

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 3'd0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (IW+1)'(grant_id) + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!sel_valid && bus.req[cand[IW-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(cand[IW-1:0]);
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++)
            if (sel_idx == 3'(i))
                sel_word = bus.word[32*i +: 32];
    end

    assign busy_rise = busy_s2 & ~busy_d;
    assign busy_fall = ~busy_s2 & busy_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            cnt         <= '0;
            busy_s1     <= 1'b0;
            busy_s2     <= 1'b0;
            busy_d      <= 1'b0;
            ack         <= '0;
            enc_data    <= '0;
            enc_load    <= 1'b0;
            enc_speed   <= 1'b1;
            grant_id    <= 3'(NREQ - 1);
            sched_busy  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            busy_s1 <= bus.enc_busy;
            busy_s2 <= busy_s1;
            busy_d  <= busy_s2;
            ack     <= '0;
            // A timeout set below overrides a same-cycle clear.
            if (bus.err_clr)
                timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!busy_s2)
                        enc_speed <= bus.speed_req;
                    if (sel_valid) begin
                        enc_data   <= format_word(sel_word);
                        ack        <= NREQ'(1) << sel_idx;
                        grant_id   <= sel_idx;
                        enc_load   <= 1'b1;
                        sched_busy <= 1'b1;
                        cnt        <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (busy_rise) begin
                        enc_load <= 1'b0;
                        cnt      <= '0;
                        state    <= SEND;
                    end else if (cnt == TIMEOUT_LIM) begin
                        timeout_err <= 1'b1;
                        enc_load    <= 1'b0;
                        cnt         <= '0;
                        state       <= GAP;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                SEND: begin
                    if (busy_fall) begin
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                GAP: begin
                    if (cnt >= GAP_LAST) begin
                        sched_busy <= 1'b0;
                        cnt        <= '0;
                        state      <= IDLE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack         = ack;
    assign bus.enc_data    = enc_data;
    assign bus.enc_load    = enc_load;
    assign bus.enc_speed   = enc_speed;
    assign bus.grant_id    = grant_id;
    assign bus.sched_busy  = sched_busy;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_arinc_tx_scheduler.sv
// Self-checking bench for arinc_tx_scheduler with a behavioural encoder and a grant scoreboard.
module tb_arinc_tx_scheduler;
    localparam int NREQ = 4;
    localparam int GAP  = 16;
    localparam int TMO  = 1023;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    arinc_tx_scheduler_if #(.NREQ(NREQ)) bus();
    arinc_tx_scheduler #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   busy_len = 100;
    bit   enc_live = 1'b1;
    int   ack_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.ack !== '0) ack_seen++;

    // Encoder: raises busy a few cycles after seeing load, holds it busy_len cycles.
    initial begin
        bus.enc_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (enc_live && bus.enc_load === 1'b1) begin
                repeat (2) @(posedge clk);
                @(negedge clk) bus.enc_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                bus.enc_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef ARINC_TX_PARITY_EN
        return {($countones(w[30:0]) % 2 == 0) ? 1'b1 : 1'b0, w[30:0]};
`else
        return w;
`endif
    endfunction

    task automatic set_word(input int i, input logic [31:0] w);
        bus.word[32*i +: 32] = w;
    endtask

    task automatic next_grant(input int bound, output bit got, output exp_t e);
        got = 1'b0;
        e   = '0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (bus.ack !== '0) begin
                got = 1'b1;
                break;
            end
        end
        if (got && sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (bus.sched_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_load_low(input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (bus.enc_load === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.enc_data !== 32'h0) begin errors++; $display("FAIL reset_enc_data got %h want 0", bus.enc_data); end
        checks++; if (bus.enc_load !== 1'b0) begin errors++; $display("FAIL reset_enc_load got %b want 0", bus.enc_load); end
        checks++; if (bus.enc_speed !== 1'b1) begin errors++; $display("FAIL reset_enc_speed got %b want 1", bus.enc_speed); end
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
        checks++; if (bus.grant_id !== 3'd3) begin errors++; $display("FAIL reset_grant_id got %0d want 3", bus.grant_id); end
        checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL reset_sched_busy got %b want 0", bus.sched_busy); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", bus.timeout_err); end
        clr = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin;
        bit   got, ok;
        exp_t e;
        int   a0;
        busy_len = 10;
        for (int i = 0; i < NREQ; i++) set_word(i, 32'h0F00_0000 | 32'(i * 17));
        for (int k = 0; k < 5; k++) sb.push_back({3'(k % NREQ), exp_word(32'h0F00_0000 | 32'((k % NREQ) * 17))});
        a0 = ack_seen;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            next_grant(300, got, e);
            checks++;
            if (!got) begin
                errors++; $display("FAIL rr_ack_timeout grant %0d got none want ack", k);
            end else begin
                checks++; if (bus.grant_id !== e.id) begin errors++; $display("FAIL rr_grant_id got %0d want %0d", bus.grant_id, e.id); end
                checks++; if (bus.ack !== (4'b1 << e.id)) begin errors++; $display("FAIL rr_ack got %b want %b", bus.ack, 4'b1 << e.id); end
                checks++; if (bus.enc_data !== e.data) begin errors++; $display("FAIL rr_enc_data got %h want %h", bus.enc_data, e.data); end
            end
            if (k == 4) bus.req = 4'b0000;
            @(negedge clk);
            checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL rr_ack_width got %b want 0000", bus.ack); end
        end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_idle got busy want idle"); end
        checks++; if (ack_seen - a0 != 5) begin errors++; $display("FAIL rr_ack_count got %0d want 5", ack_seen - a0); end
    endtask

    task automatic test_single;
        bit   got, ok;
        exp_t e;
        int   a0, gap;
        busy_len = 100;
        set_word(0, 32'h0000_00A5);
        sb.push_back({3'd0, exp_word(32'h0000_00A5)});
        a0 = ack_seen;
        bus.req = 4'b0001;
        next_grant(10, got, e);
        checks++;
        if (!got) begin
            errors++; $display("FAIL single_ack_timeout got none want ack");
        end else begin
            checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", bus.ack); end
            checks++; if (bus.enc_data !== e.data) begin errors++; $display("FAIL single_enc_data got %h want %h", bus.enc_data, e.data); end
            checks++; if (bus.enc_load !== 1'b1) begin errors++; $display("FAIL single_enc_load got %b want 1", bus.enc_load); end
        end
        bus.req = 4'b0000;
        @(negedge clk);
        checks++; if (bus.ack !== 4'b0) begin errors++; $display("FAIL single_ack_width got %b want 0000", bus.ack); end
        wait_load_low(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_load_stuck got 1 want 0"); end
        checks++; if (bus.enc_busy !== 1'b1) begin errors++; $display("FAIL single_load_before_busy busy got %b want 1", bus.enc_busy); end
        // Second word queued while the first is still on the line.
        set_word(0, 32'h0000_005A);
        sb.push_back({3'd0, exp_word(32'h0000_005A)});
        bus.req = 4'b0001;
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.enc_load === 1'b1) begin got = 1'b1; break; end
        end
        gap = cyc - fall_cyc;
        checks++;
        if (!got) begin
            errors++; $display("FAIL single_second_load got none want load");
        end else begin
            e = sb.pop_front();
            checks++; if (gap < GAP + 1 || gap > GAP + 6) begin errors++; $display("FAIL single_gap got %0d want %0d..%0d", gap, GAP + 1, GAP + 6); end
            checks++; if (bus.enc_data !== e.data) begin errors++; $display("FAIL single_enc_data2 got %h want %h", bus.enc_data, e.data); end
        end
        bus.req = 4'b0000;
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle got busy want idle"); end
        checks++; if (ack_seen - a0 != 2) begin errors++; $display("FAIL single_ack_count got %0d want 2", ack_seen - a0); end
    endtask

    task automatic test_timeout;
        bit   got, ok;
        exp_t e;
        int   n;
        enc_live = 1'b0;
        set_word(2, 32'h1234_5678);
        sb.push_back({3'd2, exp_word(32'h1234_5678)});
        bus.req = 4'b0100;
        next_grant(10, got, e);
        checks++;
        if (!got) begin
            errors++; $display("FAIL to_ack_timeout got none want ack");
        end else begin
            checks++; if (bus.grant_id !== e.id) begin errors++; $display("FAIL to_grant_id got %0d want %0d", bus.grant_id, e.id); end
        end
        bus.req = 4'b0000;
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got %b want 1", bus.timeout_err); end
        checks++; if (n < TMO || n > TMO + 2) begin errors++; $display("FAIL to_latency got %0d want %0d..%0d", n, TMO, TMO + 2); end
        checks++; if (bus.enc_load !== 1'b0) begin errors++; $display("FAIL to_enc_load got %b want 0", bus.enc_load); end
        checks++; if (bus.sched_busy !== 1'b1) begin errors++; $display("FAIL to_in_gap got %b want 1", bus.sched_busy); end
        wait_idle(40, ok);
        enc_live = 1'b1;
        checks++; if (!ok) begin errors++; $display("FAIL to_idle got busy want idle"); end
        repeat (3) @(negedge clk);
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", bus.timeout_err); end
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", bus.timeout_err); end
    endtask

    task automatic test_speed;
        bit   got, ok;
        exp_t e;
        int   bad;
        busy_len = 60;
        bus.speed_req = 1'b1;
        set_word(3, 32'h0000_0C3C);
        sb.push_back({3'd3, exp_word(32'h0000_0C3C)});
        bus.req = 4'b1000;
        next_grant(10, got, e);
        checks++;
        if (!got) begin
            errors++; $display("FAIL speed_ack_timeout got none want ack");
        end else begin
            checks++; if (bus.enc_data !== e.data) begin errors++; $display("FAIL speed_enc_data got %h want %h", bus.enc_data, e.data); end
        end
        bus.req = 4'b0000;
        wait_load_low(30, ok);
        bus.speed_req = 1'b0;
        bad = 0;
        ok  = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.sched_busy === 1'b0) begin ok = 1'b1; break; end
            if (bus.enc_speed !== 1'b1) bad++;
        end
        checks++; if (!ok) begin errors++; $display("FAIL speed_idle got busy want idle"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL speed_mid_word changes got %0d want 0", bad); end
        checks++; if (bus.enc_speed !== 1'b1) begin errors++; $display("FAIL speed_idle_entry got %b want 1", bus.enc_speed); end
        @(negedge clk);
        checks++; if (bus.enc_speed !== 1'b0) begin errors++; $display("FAIL speed_update got %b want 0", bus.enc_speed); end
        bus.speed_req = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_parity;
        bit          got, ok;
        exp_t        e;
        logic [31:0] w0, w1, w3;
`ifdef ARINC_TX_PARITY_EN
        w0 = 32'h0000_0001; w1 = 32'h0000_0001; w3 = 32'h8000_0003;
`else
        w0 = 32'h8000_0001; w1 = 32'h0000_0001; w3 = 32'h0000_0003;
`endif
        busy_len = 5;
        set_word(0, 32'h8000_0001);
        set_word(1, 32'h0000_0001);
        set_word(3, 32'h0000_0003);
        sb.push_back({3'd0, w0});
        sb.push_back({3'd1, w1});
        sb.push_back({3'd3, w3});
        bus.req = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            next_grant(200, got, e);
            checks++;
            if (!got) begin
                errors++; $display("FAIL parity_ack_timeout word %0d got none want ack", k);
            end else begin
                checks++; if (bus.grant_id !== e.id) begin errors++; $display("FAIL parity_grant got %0d want %0d", bus.grant_id, e.id); end
                checks++; if (bus.enc_data !== e.data) begin errors++; $display("FAIL parity_enc_data got %h want %h", bus.enc_data, e.data); end
            end
            bus.req = bus.req & ~bus.ack;
        end
        bus.req = 4'b0000;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL parity_idle got busy want idle"); end
    endtask

    task automatic test_reset_mid;
        bit   got, ok;
        exp_t e;
        int   a0;
        busy_len = 100;
        set_word(0, 32'h0000_0077);
        sb.push_back({3'd0, exp_word(32'h0000_0077)});
        bus.req = 4'b0001;
        next_grant(10, got, e);
        checks++; if (!got) begin errors++; $display("FAIL mid_ack_timeout got none want ack"); end
        bus.req = 4'b0000;
        wait_load_low(30, ok);
        repeat (5) @(negedge clk);
        a0 = ack_seen;
        clr = 1'b0;
        #2;
        checks++; if (bus.enc_data !== 32'h0) begin errors++; $display("FAIL mid_enc_data got %h want 0", bus.enc_data); end
        checks++; if (bus.enc_load !== 1'b0) begin errors++; $display("FAIL mid_enc_load got %b want 0", bus.enc_load); end
        checks++; if (bus.enc_speed !== 1'b1) begin errors++; $display("FAIL mid_enc_speed got %b want 1", bus.enc_speed); end
        checks++; if (bus.grant_id !== 3'd3) begin errors++; $display("FAIL mid_grant_id got %0d want 3", bus.grant_id); end
        checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL mid_sched_busy got %b want 0", bus.sched_busy); end
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ack_seen != a0) begin errors++; $display("FAIL mid_no_reack got %0d want %0d", ack_seen - a0, 0); end
        set_word(1, 32'h0000_0202);
        sb.push_back({3'd1, exp_word(32'h0000_0202)});
        bus.req = 4'b0010;
        next_grant(10, got, e);
        checks++;
        if (!got) begin
            errors++; $display("FAIL mid_grant_timeout got none want ack");
        end else begin
            checks++; if (bus.ack !== 4'b0010) begin errors++; $display("FAIL mid_ack got %b want 0010", bus.ack); end
            checks++; if (bus.grant_id !== e.id) begin errors++; $display("FAIL mid_grant got %0d want %0d", bus.grant_id, e.id); end
            checks++; if (bus.enc_data !== e.data) begin errors++; $display("FAIL mid_data got %h want %h", bus.enc_data, e.data); end
        end
        bus.req = 4'b0000;
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_idle got busy want idle"); end
    endtask

    initial begin
        bus.req       = '0;
        bus.word      = '0;
        bus.speed_req = 1'b1;
        bus.err_clr   = 1'b0;
        test_reset;
        test_round_robin;
        test_single;
        test_timeout;
        test_speed;
        test_parity;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
